// File: rtl/edac_4bit_a_pkg.sv
// Shared constants for the 4-nibble GF(16) EDAC: field, locator coefficients, widths.
// Pure declarations; no logic.
package edac_4bit_a_pkg;

    localparam int DATA_W = 16;
    localparam int CHK_W  = 8;
    localparam int SYM_W  = 4;
    localparam int NIB_N  = DATA_W / SYM_W;

    // Low-order terms of x^4+x+1, folded back in when a product overflows bit 3.
    localparam logic [SYM_W-1:0] GF_POLY = 4'h3;

    localparam logic [SYM_W-1:0] A1 = 4'h2;
    localparam logic [SYM_W-1:0] A2 = 4'h4;
    localparam logic [SYM_W-1:0] A3 = 4'h8;
    localparam logic [SYM_W-1:0] A4 = 4'h3;

    // Entry i is the coefficient applied to data nibble d_i.
    localparam logic [NIB_N-1:0][SYM_W-1:0] ALPHA = {A4, A3, A2, A1};

endpackage

// File: rtl/edac_4bit_a_gf16_mul.sv
// Combinational GF(16) multiplier over x^4+x+1, built from shift/XOR stages.
// Latency 0; no flow control.
module gf16_mul
    import edac_4bit_a_pkg::*;
(
    input  logic [SYM_W-1:0] a,
    input  logic [SYM_W-1:0] b,
    output logic [SYM_W-1:0] p
);

    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] sh;

    always_comb begin
        acc = '0;
        sh  = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[SYM_W-1] ? ({sh[SYM_W-2:0], 1'b0} ^ GF_POLY) : {sh[SYM_W-2:0], 1'b0};
        end
        p = acc;
    end

endmodule

// File: rtl/edac_4bit_a.sv
// Single-nibble-correcting EDAC for a 16-bit word with an 8-bit GF(16) check byte.
// Latency 1 cycle for read results and write check bytes; accepts an access every cycle, no backpressure.
module edac_4bit_a
    import edac_4bit_a_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              READ,
    input  logic [DATA_W-1:0] DIN,
    input  logic [CHK_W-1:0]  CRC,
    output logic [DATA_W-1:0] DOUT,
    output logic              valid,
    output logic [CHK_W-1:0]  CRC_OUT,
    output logic              err_corr,
    output logic              err_uncorr
);

    logic [NIB_N-1:0][SYM_W-1:0] nib;
    logic [NIB_N-1:0][SYM_W-1:0] enc_prod;
    logic [NIB_N-1:0][SYM_W-1:0] loc_prod;
    logic [SYM_W-1:0]            c0;
    logic [SYM_W-1:0]            c1;
    logic [SYM_W-1:0]            s0;
    logic [SYM_W-1:0]            s1;

    assign nib = DIN;

    // enc_prod feeds the check byte; loc_prod is a(i+1)*s0 for the locator match.
    for (genvar g = 0; g < NIB_N; g++) begin : g_mul
        gf16_mul u_enc (.a(ALPHA[g]), .b(nib[g]), .p(enc_prod[g]));
        gf16_mul u_loc (.a(ALPHA[g]), .b(s0),     .p(loc_prod[g]));
    end

    always_comb begin
        c0 = '0;
        c1 = '0;
        for (int i = 0; i < NIB_N; i++) begin
            c0 = c0 ^ nib[i];
            c1 = c1 ^ enc_prod[i];
        end
    end

    assign s0 = c0 ^ CRC[SYM_W-1:0];
    assign s1 = c1 ^ CRC[CHK_W-1:SYM_W];

    logic [NIB_N-1:0][SYM_W-1:0] fixed;
    logic                        dec_corr;
    logic                        dec_uncorr;

    always_comb begin
        fixed      = nib;
        dec_corr   = 1'b0;
        dec_uncorr = 1'b0;
        if ((s0 == '0) && (s1 == '0)) begin
            dec_corr = 1'b0;
        end else if ((s0 == '0) != (s1 == '0)) begin
            // Only one check nibble disagrees: the damage is in the stored check byte.
            dec_corr = 1'b1;
        end else begin
            dec_uncorr = 1'b1;
            for (int i = 0; i < NIB_N; i++) begin
                if (!dec_corr && (loc_prod[i] == s1)) begin
                    fixed[i]   = nib[i] ^ s0;
                    dec_corr   = 1'b1;
                    dec_uncorr = 1'b0;
                end
            end
        end
    end

    logic [DATA_W-1:0] dout_d,       dout_q;
    logic [CHK_W-1:0]  crc_out_d,    crc_out_q;
    logic              valid_d,      valid_q;
    logic              err_corr_d,   err_corr_q;
    logic              err_uncorr_d, err_uncorr_q;

    always_comb begin
        dout_d       = dout_q;
        crc_out_d    = crc_out_q;
        valid_d      = 1'b0;
        err_corr_d   = 1'b0;
        err_uncorr_d = 1'b0;
        if (en) begin
            if (READ) begin
                // Uncorrectable reads leave fixed == DIN, so raw data passes through.
                dout_d       = fixed;
                valid_d      = !dec_uncorr;
                err_corr_d   = dec_corr;
                err_uncorr_d = dec_uncorr;
            end else begin
                crc_out_d = {c1, c0};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q       <= '0;
            crc_out_q    <= '0;
            valid_q      <= 1'b0;
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            crc_out_q    <= crc_out_d;
            valid_q      <= valid_d;
            err_corr_q   <= err_corr_d;
            err_uncorr_q <= err_uncorr_d;
        end
    end

    assign DOUT       = dout_q;
    assign CRC_OUT    = crc_out_q;
    assign valid      = valid_q;
    assign err_corr   = err_corr_q;
    assign err_uncorr = err_uncorr_q;

endmodule

// File: tb/tb_edac_4bit_a.sv
// Directed bench for edac_4bit_a with hand-computed expectations.
module tb_edac_4bit_a;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en;
    logic        READ;
    logic [15:0] DIN;
    logic [7:0]  CRC;
    logic [15:0] DOUT;
    logic        valid;
    logic [7:0]  CRC_OUT;
    logic        err_corr;
    logic        err_uncorr;

    int total = 0;
    int bad   = 0;

    edac_4bit_a dut (
        .CLK(CLK), .RST(RST), .en(en), .READ(READ), .DIN(DIN), .CRC(CRC),
        .DOUT(DOUT), .valid(valid), .CRC_OUT(CRC_OUT),
        .err_corr(err_corr), .err_uncorr(err_uncorr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic rd,
                         input logic [15:0] d, input logic [7:0] c);
        @(negedge CLK);
        RST = r; en = e; READ = rd; DIN = d; CRC = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [15:0] d,
                          input logic v, input logic ec, input logic eu);
        chk({tag, "_dout"}, DOUT, d);
        chk({tag, "_valid"}, {15'd0, valid}, {15'd0, v});
        chk({tag, "_corr"}, {15'd0, err_corr}, {15'd0, ec});
        chk({tag, "_uncorr"}, {15'd0, err_uncorr}, {15'd0, eu});
    endtask

    initial begin
        RST = 1'b1; en = 1'b0; READ = 1'b0; DIN = '0; CRC = '0;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk_rd("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("reset_crc", {8'd0, CRC_OUT}, 16'h0000);

        drive(1'b0, 1'b1, 1'b1, 16'h03F8, 8'h14);
        chk_rd("clean", 16'h03F8, 1'b1, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 1'b1, 16'h0FF8, 8'h14);
        chk_rd("data_err", 16'h03F8, 1'b1, 1'b1, 1'b0);

        drive(1'b0, 1'b1, 1'b1, 16'h03F8, 8'h1B);
        chk_rd("chk_err", 16'h03F8, 1'b1, 1'b1, 1'b0);

        drive(1'b0, 1'b1, 1'b1, 16'h17F8, 8'h14);
        chk_rd("two_nib", 16'h17F8, 1'b0, 1'b0, 1'b1);

        drive(1'b0, 1'b1, 1'b0, 16'h03F8, 8'h00);
        chk("write_crc", {8'd0, CRC_OUT}, 16'h0014);
        chk_rd("write", 16'h17F8, 1'b0, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 8'hFF);
        chk_rd("idle", 16'h17F8, 1'b0, 1'b0, 1'b0);
        chk("idle_crc", {8'd0, CRC_OUT}, 16'h0014);

        // Pattern 0x9 dropped into each data nibble must always correct back.
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e;
            e = 16'h0009 << (4 * i);
            drive(1'b0, 1'b1, 1'b1, 16'h03F8 ^ e, 8'h14);
            chk_rd($sformatf("sweep_d%0d", i), 16'h03F8, 1'b1, 1'b1, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1, 16'h03F8, 8'h1D);
        chk_rd("sweep_c0", 16'h03F8, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 16'h03F8, 8'h94);
        chk_rd("sweep_c1", 16'h03F8, 1'b1, 1'b1, 1'b0);

        // Reset wins over a read presented on the same edge.
        drive(1'b1, 1'b1, 1'b1, 16'h0FF8, 8'h14);
        chk_rd("rst_rd", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("rst_rd_crc", {8'd0, CRC_OUT}, 16'h0000);

        drive(1'b0, 1'b1, 1'b1, 16'h03F8, 8'h14);
        chk_rd("post_rst1", 16'h03F8, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 16'h0FF8, 8'h14);
        chk_rd("post_rst2", 16'h03F8, 1'b1, 1'b1, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        chk_rd("final_idle", 16'h03F8, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edac_4bit_a.md
EDAC_4BIT_A -- requirements
Module: edac_4bit_a

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
- CLK, input, 1 bit: the only clock; all state updates on the rising edge.
- RST, input, 1 bit: synchronous reset, active high.
REQ-002 It SHALL have these inputs:
- en, input, 1 bit: access enable, sampled each rising edge.
- READ, input, 1 bit: 1 = read/check/correct access, 0 = write/encode access.
- DIN, input, 16 bits: data word (raw memory data on read, write data on write).
- CRC, input, 8 bits: stored check byte accompanying DIN on read.
REQ-003 It SHALL have these outputs:
- DOUT, output, 16 bits: registered corrected read data.
- valid, output, 1 bit: registered; trustworthy read data present.
- CRC_OUT, output, 8 bits: registered check byte generated on write.
- err_corr, output, 1 bit: registered; read had a correctable error.
- err_uncorr, output, 1 bit: registered; read had an uncorrectable error.

Function
REQ-004 Code: DIN split into nibbles d0=DIN[3:0] … d3=DIN[15:12], treated as GF(16) symbols, field polynomial x^4+x+1, alpha=0x2.
REQ-005 Check nibbles: c0 = d0^d1^d2^d3; c1 = a1·d0 ^ a2·d1 ^ a3·d2 ^ a4·d3, where a1=0x2, a2=0x4, a3=0x8, a4=0x3. Check byte = {c1,c0}.
REQ-006 Syndromes (read): s0 = c0(DIN)^CRC[3:0]; s1 = c1(DIN)^CRC[7:4].
REQ-007 Decode cases:
- s0=0, s1=0: no error.
- Exactly one syndrome nonzero: error confined to check byte; data passes unchanged; err_corr=1.
- Both nonzero and a(i+1)·s0 == s1 for some i in 0..3: nibble di is XORed with s0; err_corr=1.
- Otherwise: uncorrectable.
REQ-008 Read (en=1, READ=1 at an edge): on that edge DOUT, valid, err_corr and err_uncorr load the decode result.
- Latency is 1 cycle; back-to-back reads are accepted every cycle.
REQ-009 On an uncorrectable read: DOUT=DIN unchanged, valid=0, err_uncorr=1, err_corr=0.
- On any other read: valid=1, err_uncorr=0.
REQ-010 Write (en=1, READ=0 at an edge): CRC_OUT loads {c1,c0} of DIN.
- valid, err_corr and err_uncorr clear to 0; DOUT holds its value.
REQ-011 Idle (en=0): valid, err_corr and err_uncorr clear to 0; DOUT and CRC_OUT hold.
- READ and DIN are don't-care when en=0.
REQ-012 GF multiplication by constants SHALL be pure combinational XOR logic; no lookup tables or ROMs.
REQ-013 Miscorrection of errors spanning 2 or more nibbles is not guaranteed to be detected; single-nibble errors (any of 15 patterns in any of 6 nibbles) SHALL always be corrected.

Reset
REQ-014 RST=1 at an edge SHALL set DOUT=0x0000, CRC_OUT=0x00, valid=0, err_corr=0, err_uncorr=0.
REQ-015 Reset SHALL dominate en; a read presented in the same cycle as reset SHALL be discarded.

Structure
REQ-016 A shared package SHALL hold:
- the field polynomial constant (4'h3 low terms);
- the constants a1..a4;
- the check-byte width (8) and data width (16).
REQ-017 A sub-module gf16_mul (combinational 4x4 GF(16) multiplier) SHALL be used.
- Instantiated for encoding, syndrome and locator comparison.

Verification
REQ-018 Clean read: DIN=0x03F8, CRC=0x14 -> next edge DOUT=0x03F8, valid=1, err_corr=0, err_uncorr=0.
REQ-019 Data nibble error: DIN=0x0FF8, CRC=0x14 (s0=0xC, s1=0xA) -> DOUT=0x03F8, valid=1, err_corr=1.
REQ-020 Check-nibble error: DIN=0x03F8, CRC=0x1B -> DOUT=0x03F8, valid=1, err_corr=1.
REQ-021 Two-nibble error: DIN=0x17F8, CRC=0x14 (s0=s1=0x5) -> DOUT=0x17F8, valid=0, err_uncorr=1.
REQ-022 Write: en=1, READ=0, DIN=0x03F8 -> CRC_OUT=0x14, valid=0.
REQ-023 Reset asserted during a read cycle -> all outputs zero on that edge; en held for 2 cycles yields valid high for both cycles after reset release.
